// File: rtl/taumin_filter_pkg.sv
// ============================================================================
// taumin_filter_pkg : shared types, FSM encodings and default bounds
// Revision: 1.0
// ============================================================================
`default_nettype none

package taumin_filter_pkg;

    typedef logic [10:0] tau_t;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_SORT  = 2'd2;
    localparam logic [1:0] ST_JUDGE = 2'd3;

    localparam int TAU_MIN_DEFAULT = 20;
    localparam int TAU_MAX_DEFAULT = 2000;

endpackage

`default_nettype wire

// File: rtl/taumin_cmp_swap.sv
// ============================================================================
// taumin_cmp_swap : combinational compare-and-swap, o_lo <= o_hi
// Revision: 1.0
// ============================================================================
`default_nettype none

module taumin_cmp_swap
    import taumin_filter_pkg::*;
#(
    parameter int WIDTH = $bits(tau_t)
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    logic w_swap;

    assign w_swap = (i_a > i_b);
    assign o_lo   = w_swap ? i_b : i_a;
    assign o_hi   = w_swap ? i_a : i_b;

endmodule

`default_nettype wire

// File: rtl/taumin_filter.sv
// ============================================================================
// taumin_filter : range check, DEPTH-tap median and jump hysteresis on taumin.
// Optional TAUMIN_FILTER_STATS_EN adds reject / withheld-median counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module taumin_filter
    import taumin_filter_pkg::*;
#(
    parameter int WIDTH          = 11,
    parameter int DEPTH          = 5,
    parameter int TAU_MIN        = TAU_MIN_DEFAULT,
    parameter int TAU_MAX        = TAU_MAX_DEFAULT,
    parameter int MAX_JUMP       = 64,
    parameter int UNLOCK_REJECTS = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] taumin_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] taumin_out,
    output logic             valid_out,
    output logic             locked_out
`ifdef TAUMIN_FILTER_STATS_EN
    ,
    output logic [15:0]      reject_count_out,
    output logic [15:0]      jump_hold_count_out
`endif
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PASS_W = $clog2(DEPTH + 1);
    localparam int REJ_W  = $clog2(UNLOCK_REJECTS + 1);
    localparam int NPAIR  = DEPTH / 2;

    function automatic logic [WIDTH:0] f_abs_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    logic [WIDTH-1:0]  r_hist [DEPTH];
    logic [WIDTH-1:0]  r_sort [DEPTH];
    logic [CNT_W-1:0]  r_fill;
    logic [REJ_W-1:0]  r_rej;
    logic [PASS_W-1:0] r_pass;
    logic [1:0]        r_state;
    logic              r_pending;
    logic [WIDTH-1:0]  r_pend_val;
    logic [WIDTH-1:0]  r_tau_out;
    logic              r_valid_out;
    logic              r_locked;

    logic [WIDTH-1:0]  w_hist_next [DEPTH];
    logic [WIDTH-1:0]  w_sort_next [DEPTH];
    logic [WIDTH-1:0]  w_pair_a  [NPAIR];
    logic [WIDTH-1:0]  w_pair_b  [NPAIR];
    logic [WIDTH-1:0]  w_pair_lo [NPAIR];
    logic [WIDTH-1:0]  w_pair_hi [NPAIR];
    logic              w_in_range, w_push, w_rej, w_unlock, w_launch;
    logic [CNT_W-1:0]  w_fill_next;
    logic [REJ_W-1:0]  w_rej_next;
    logic [WIDTH-1:0]  w_median;
    logic              w_judge, w_ok_out, w_ok_pend, w_accept, w_hold;

    assign w_in_range  = (taumin_in >= WIDTH'(TAU_MIN)) && (taumin_in <= WIDTH'(TAU_MAX));
    assign w_push      = valid_in && w_in_range;
    assign w_rej       = valid_in && !w_in_range;
    assign w_fill_next = (r_fill == CNT_W'(DEPTH)) ? r_fill : r_fill + 1'b1;
    assign w_rej_next  = (r_rej == REJ_W'(UNLOCK_REJECTS)) ? r_rej : r_rej + 1'b1;
    assign w_unlock    = w_rej && (w_rej_next == REJ_W'(UNLOCK_REJECTS));

    // The push that completes the window launches a median, so the first lock
    // follows the DEPTH-th accepted sample with the normal pipeline latency.
    assign w_launch = w_push && (w_fill_next == CNT_W'(DEPTH))
                   && ((r_state == ST_FILL) || (r_state == ST_IDLE));

    always_comb begin
        w_hist_next[0] = taumin_in;
        for (int i = 1; i < DEPTH; i++) begin
            w_hist_next[i] = r_hist[i-1];
        end
    end

    // Pass parity picks the pairing: even passes (0,1),(2,3)..., odd passes (1,2),(3,4)...
    for (genvar p = 0; p < NPAIR; p++) begin : g_pair
        assign w_pair_a[p] = r_pass[0] ? r_sort[2*p+1] : r_sort[2*p];
        assign w_pair_b[p] = r_pass[0] ? r_sort[2*p+2] : r_sort[2*p+1];
        taumin_cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
            .i_a  (w_pair_a[p]),
            .i_b  (w_pair_b[p]),
            .o_lo (w_pair_lo[p]),
            .o_hi (w_pair_hi[p])
        );
    end

    always_comb begin
        w_sort_next = r_sort;
        for (int p = 0; p < NPAIR; p++) begin
            if (r_pass[0]) begin
                w_sort_next[2*p+1] = w_pair_lo[p];
                w_sort_next[2*p+2] = w_pair_hi[p];
            end else begin
                w_sort_next[2*p]   = w_pair_lo[p];
                w_sort_next[2*p+1] = w_pair_hi[p];
            end
        end
    end

    assign w_median  = r_sort[DEPTH/2];
    assign w_judge   = (r_state == ST_JUDGE);
    assign w_ok_out  = f_abs_diff(w_median, r_tau_out) <= (WIDTH+1)'(MAX_JUMP);
    assign w_ok_pend = r_pending && (f_abs_diff(w_median, r_pend_val) <= (WIDTH+1)'(MAX_JUMP));
    assign w_accept  = w_judge && (!r_locked || w_ok_out || w_ok_pend);
    assign w_hold    = w_judge && !w_accept;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
                r_sort[i] <= '0;
            end
            r_fill      <= '0;
            r_rej       <= '0;
            r_pass      <= '0;
            r_state     <= ST_FILL;
            r_pending   <= 1'b0;
            r_pend_val  <= '0;
            r_tau_out   <= '0;
            r_valid_out <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            if (w_push) begin
                r_hist <= w_hist_next;
                r_fill <= w_fill_next;
                r_rej  <= '0;
            end else if (w_rej) begin
                r_rej <= w_rej_next;
            end

            case (r_state)
                ST_FILL, ST_IDLE: begin
                    if (w_launch) begin
                        r_sort  <= w_hist_next;
                        r_pass  <= '0;
                        r_state <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    r_sort <= w_sort_next;
                    r_pass <= r_pass + 1'b1;
                    if (r_pass == PASS_W'(DEPTH - 1)) begin
                        r_state <= ST_JUDGE;
                    end
                end
                ST_JUDGE: begin
                    r_state <= ((w_push ? w_fill_next : r_fill) == CNT_W'(DEPTH)) ? ST_IDLE : ST_FILL;
                    if (w_accept) begin
                        r_tau_out   <= w_median;
                        r_valid_out <= 1'b1;
                        r_locked    <= 1'b1;
                        r_pending   <= 1'b0;
                    end
                    if (w_hold) begin
                        r_pend_val <= w_median;
                        r_pending  <= 1'b1;
                    end
                end
                default: r_state <= ST_FILL;
            endcase

            // Unlock overrides everything above; the last output value is kept.
            if (w_unlock) begin
                r_locked  <= 1'b0;
                r_fill    <= '0;
                r_pending <= 1'b0;
                if ((r_state == ST_FILL) || (r_state == ST_IDLE)) begin
                    r_state <= ST_FILL;
                end
            end
        end
    end

    assign taumin_out = r_tau_out;
    assign valid_out  = r_valid_out;
    assign locked_out = r_locked;

`ifdef TAUMIN_FILTER_STATS_EN
    logic [15:0] r_reject_cnt;
    logic [15:0] r_hold_cnt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_reject_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            if (w_rej && (r_reject_cnt != 16'hFFFF)) begin
                r_reject_cnt <= r_reject_cnt + 16'd1;
            end
            if (w_hold && (r_hold_cnt != 16'hFFFF)) begin
                r_hold_cnt <= r_hold_cnt + 16'd1;
            end
        end
    end

    assign reject_count_out    = r_reject_cnt;
    assign jump_hold_count_out = r_hold_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_taumin_filter.sv
// ============================================================================
// tb_taumin_filter : directed + random stimulus, queue-based reference model,
// scoreboard monitor comparing every output strobe, lock flag and held value.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_taumin_filter;

    logic        clk_in    = 1'b0;
    logic        rst_in    = 1'b0;
    logic [10:0] taumin_in = '0;
    logic        valid_in  = 1'b0;
    logic [10:0] taumin_out;
    logic        valid_out;
    logic        locked_out;

    taumin_filter u_dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .taumin_in  (taumin_in),
        .valid_in   (valid_in),
        .taumin_out (taumin_out),
        .valid_out  (valid_out),
        .locked_out (locked_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int val;
        int due;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t sb[$];

    // reference model state
    int hist[$];
    int m_rej, m_pend_val, m_out, judge_cnt, judge_med;
    bit m_locked, m_pend;
    bit m_locked_vis;
    int m_out_vis;

    function automatic int f_absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int f_median();
        int q[$];
        q = hist;
        q.sort();
        return q[q.size() / 2];
    endfunction

    task automatic model_reset();
        hist.delete();
        sb.delete();
        m_rej = 0; m_pend_val = 0; m_out = 0; judge_cnt = 0; judge_med = 0;
        m_locked = 0; m_pend = 0;
        m_locked_vis = 0; m_out_vis = 0;
    endtask

    task automatic model_judge(input int m);
        if (!m_locked || f_absd(m, m_out) <= 64 || (m_pend && f_absd(m, m_pend_val) <= 64)) begin
            m_out    = m;
            m_locked = 1;
            m_pend   = 0;
            sb.push_back('{val: m, due: cyc + 1});
        end else begin
            m_pend     = 1;
            m_pend_val = m;
        end
    endtask

    // One clock edge of the model, called with the inputs about to be sampled.
    task automatic model_step(input bit v, input int t);
        bit judged;
        judged = 0;
        if (judge_cnt > 0) begin
            judge_cnt--;
            if (judge_cnt == 0) begin
                judged = 1;
                model_judge(judge_med);
            end
        end
        if (v) begin
            if (t < 20 || t > 2000) begin
                if (m_rej < 8) m_rej++;
                if (m_rej == 8) begin
                    m_locked = 0;
                    m_pend   = 0;
                    hist.delete();
                end
            end else begin
                m_rej = 0;
                hist.push_back(t);
                if (hist.size() > 5) void'(hist.pop_front());
                if (hist.size() == 5 && judge_cnt == 0 && !judged) begin
                    judge_med = f_median();
                    judge_cnt = 6;
                end
            end
        end
    endtask

    task automatic tick(input bit v, input int t);
        @(negedge clk_in);
        valid_in  = v;
        taumin_in = 11'(t);
        if (rst_in) model_step(v, t);
        @(posedge clk_in);
        m_locked_vis = m_locked;
        m_out_vis    = m_out;
    endtask

    task automatic send(input int t, input int gap);
        tick(1'b1, t);
        repeat (gap) tick(1'b0, 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_in);
        rst_in   = 1'b0;
        valid_in = 1'b0;
        model_reset();
        repeat (n) begin
            @(negedge clk_in);
            valid_in  = ($urandom_range(0, 1) == 1);
            taumin_in = 11'($urandom_range(20, 2000));
        end
        @(negedge clk_in);
        rst_in   = 1'b1;
        valid_in = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int req);
        #1;
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            cyc++;
            #1;
            if (!rst_in) begin
                n_cmp++;
                if (valid_out !== 1'b0 || taumin_out !== 11'd0 || locked_out !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_outputs: valid=%b taumin=%0d locked=%b, required all zero",
                             valid_out, taumin_out, locked_out);
                end
            end else begin
                if (valid_out === 1'b1) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_valid: taumin_out=%0d at cycle %0d, required no strobe",
                                 taumin_out, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (taumin_out !== 11'(e.val) || cyc != e.due) begin
                            n_bad++;
                            $display("FAIL output_strobe: got %0d at cycle %0d, required %0d at cycle %0d",
                                     taumin_out, cyc, e.val, e.due);
                        end
                    end
                end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing_valid: no strobe at cycle %0d, required taumin_out=%0d",
                             cyc, sb[0].val);
                    void'(sb.pop_front());
                end
                n_cmp++;
                if (locked_out !== m_locked_vis) begin
                    n_bad++;
                    $display("FAIL locked_flag: got %b at cycle %0d, required %b", locked_out, cyc, m_locked_vis);
                end
                n_cmp++;
                if (taumin_out !== 11'(m_out_vis)) begin
                    n_bad++;
                    $display("FAIL held_value: got %0d at cycle %0d, required %0d", taumin_out, cyc, m_out_vis);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        model_reset();
        do_reset(6);

        // fill and first lock
        send(100, 49); send(102, 49); send(98, 49); send(101, 49); send(99, 49);
        check("first_lock_value", int'(taumin_out), 100);
        check("first_lock_flag", int'(locked_out), 1);

        send(500, 49);
        check("outlier_median", int'(taumin_out), 101);

        send(10, 49); send(2047, 49);
        check("rejects_hold_value", int'(taumin_out), 101);
        send(100, 49);
        check("post_reject_median", int'(taumin_out), 100);

        // octave jump needs a second confirming median
        send(200, 49);
        check("octave_first", int'(taumin_out), 101);
        send(200, 49);
        check("octave_withheld", int'(taumin_out), 101);
        send(200, 49);
        check("octave_confirmed", int'(taumin_out), 200);

        repeat (8) send(5, 3);
        check("unlock_flag", int'(locked_out), 0);
        check("unlock_keeps_value", int'(taumin_out), 200);
        repeat (4) send(300, 20);
        check("refill_no_output", int'(taumin_out), 200);
        send(300, 20);
        check("relock_value", int'(taumin_out), 300);
        check("relock_flag", int'(locked_out), 1);

        // reset three cycles into a sort
        send(400, 3);
        do_reset(2);
        repeat (20) tick(1'b0, 0);
        check("reset_mid_sort_value", int'(taumin_out), 0);

        // randomized traffic
        base = 150;
        for (int k = 0; k < 300; k++) begin
            int r;
            int v;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                for (int j = 0; j < 9; j++) send(int'($urandom_range(0, 19)), int'($urandom_range(0, 3)));
                base = int'($urandom_range(30, 900));
            end else begin
                if (r < 10)      v = r[0] ? int'($urandom_range(0, 19)) : int'($urandom_range(2001, 2047));
                else if (r < 22) v = base * 2;
                else if (r < 30) v = base + int'($urandom_range(0, 200));
                else             v = base + int'($urandom_range(0, 20)) - 10;
                if (r >= 97) base = int'($urandom_range(30, 900));
                send(v, int'($urandom_range(0, 10)));
            end
        end

        repeat (20) tick(1'b0, 0);
        check("scoreboard_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
